// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: the machine word, the RAM status encoding and
// the memory arbiter states.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arbstate_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set request at or after ptr (wrapping), returned
// both as a one-hot grant and as an index.
module rr_picker #(
    parameter int W  = 4,
    parameter int IW = (W > 1) ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [W-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    int j;

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        for (int i = W - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= W) begin
                j = j - W;
            end
            if (req[IW'(j)]) begin
                gnt          = '0;
                gnt[IW'(j)]  = 1'b1;
                idx          = IW'(j);
                any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single RAM port among the per-core icaches and dcaches.
// Build option MEM_ARB_DPRIO_EN: dcache requests beat icache requests.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int CPUS      = 2,
    parameter int MAX_BURST = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CPUS-1:0]           iREN,
    input  logic [WORD_W*CPUS-1:0]    iaddr,
    output logic [CPUS-1:0]           iwait,
    output logic [WORD_W*CPUS-1:0]    iload,
    input  logic [CPUS-1:0]           dREN,
    input  logic [CPUS-1:0]           dWEN,
    input  logic [WORD_W*CPUS-1:0]    daddr,
    input  logic [WORD_W*CPUS-1:0]    dstore,
    output logic [CPUS-1:0]           dwait,
    output logic [WORD_W*CPUS-1:0]    dload,
    output logic                      ramREN,
    output logic                      ramWEN,
    output word_t                     ramaddr,
    output word_t                     ramstore,
    input  word_t                     ramload,
    input  ramstate_t                 ramstate,
    output logic                      arb_err,
    output arbstate_t                 arb_state,
    output logic [$clog2(2*CPUS)-1:0] arb_owner
);

    localparam int N  = 2 * CPUS;
    localparam int IW = $clog2(N);
    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    // Handshake: a requester raises its enable(s) with address/data and holds
    // them until its wait drops; the cycle with wait low is the transfer, and
    // load is valid in that cycle. Requester 2c is dcache c, 2c+1 is icache c.
    arbstate_t     state, state_n;
    logic [IW-1:0] owner, owner_n;
    logic [N-1:0]  owner_oh, owner_oh_n;
    logic [BW-1:0] burst, burst_n;
    logic          err_set;
    logic          advance;

    logic [N-1:0]  req;
    logic [N-1:0]  win_oh;
    logic [IW-1:0] win_idx;
    logic          win_any;
    logic          own_req;
    logic          own_icache;
    logic [CW-1:0] own_core;

    always_comb begin
        req = '0;
        for (int c = 0; c < CPUS; c++) begin
            req[2*c]   = dREN[c] | dWEN[c];
            req[2*c+1] = iREN[c];
        end
    end

    assign own_req    = |(req & owner_oh);
    assign own_icache = owner[0];
    assign own_core   = CW'(owner >> 1);
    assign arb_state  = state;
    assign arb_owner  = owner;

`ifdef MEM_ARB_DPRIO_EN
    logic [CW-1:0]   dptr, iptr, didx, iidx, next_core;
    logic [CPUS-1:0] dreq, ireq, dgnt, ignt;
    logic            dany, iany;

    assign dreq = dREN | dWEN;
    assign ireq = iREN;

    rr_picker #(.W(CPUS), .IW(CW)) u_dpick (
        .req (dreq),
        .ptr (dptr),
        .gnt (dgnt),
        .idx (didx),
        .any (dany)
    );

    rr_picker #(.W(CPUS), .IW(CW)) u_ipick (
        .req (ireq),
        .ptr (iptr),
        .gnt (ignt),
        .idx (iidx),
        .any (iany)
    );

    always_comb begin
        win_oh = '0;
        for (int c = 0; c < CPUS; c++) begin
            win_oh[2*c]   = dany & dgnt[c];
            win_oh[2*c+1] = ~dany & ignt[c];
        end
    end

    assign win_any   = dany | iany;
    assign win_idx   = dany ? IW'({didx, 1'b0}) : IW'({iidx, 1'b1});
    assign next_core = (own_core == CW'(CPUS - 1)) ? '0 : own_core + CW'(1);

    // Each class keeps its own pointer; only the releasing class advances.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dptr <= '0;
            iptr <= '0;
        end else if (advance) begin
            if (own_icache) begin
                iptr <= next_core;
            end else begin
                dptr <= next_core;
            end
        end
    end
`else
    logic [IW-1:0] rr_ptr;

    rr_picker #(.W(N), .IW(IW)) u_pick (
        .req (req),
        .ptr (rr_ptr),
        .gnt (win_oh),
        .idx (win_idx),
        .any (win_any)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (owner == IW'(N - 1)) ? '0 : owner + IW'(1);
        end
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= ARB_IDLE;
            owner    <= '0;
            owner_oh <= '0;
            burst    <= '0;
            arb_err  <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            owner_oh <= owner_oh_n;
            burst    <= burst_n;
            arb_err  <= arb_err | err_set;
        end
    end

    // An ERROR release leaves the pointer alone so the same owner retries.
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        owner_oh_n = owner_oh;
        burst_n    = burst;
        err_set    = 1'b0;
        advance    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (win_any) begin
                    state_n    = ARB_GRANT;
                    owner_n    = win_idx;
                    owner_oh_n = win_oh;
                    burst_n    = '0;
                end
            end
            ARB_GRANT: begin
                if (ramstate == ERROR) begin
                    err_set = 1'b1;
                    state_n = ARB_IDLE;
                end else if (!own_req) begin
                    state_n = ARB_IDLE;
                    advance = 1'b1;
                end else if (ramstate == ACCESS) begin
                    if (burst != BW'(MAX_BURST)) begin
                        burst_n = burst + BW'(1);
                    end
                    if (own_icache || (burst_n == BW'(MAX_BURST))) begin
                        state_n = ARB_IDLE;
                        advance = 1'b1;
                    end
                end
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    // Owner routing; a dcache write wins over a simultaneous read.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = '1;
        dwait    = '1;
        iload    = '0;
        dload    = '0;
        if (state == ARB_GRANT) begin
            for (int c = 0; c < CPUS; c++) begin
                if (own_core == CW'(c)) begin
                    if (own_icache) begin
                        ramREN                      = iREN[c];
                        ramaddr                     = iaddr[WORD_W*c +: WORD_W];
                        iwait[c]                    = (ramstate != ACCESS);
                        iload[WORD_W*c +: WORD_W]   = ramload;
                    end else begin
                        ramWEN                      = dWEN[c];
                        ramREN                      = dREN[c] & ~dWEN[c];
                        ramaddr                     = daddr[WORD_W*c +: WORD_W];
                        ramstore                    = dstore[WORD_W*c +: WORD_W];
                        dwait[c]                    = (ramstate != ACCESS);
                        dload[WORD_W*c +: WORD_W]   = ramload;
                    end
                end
            end
            if (ramstate == ERROR) begin
                ramREN = 1'b0;
                ramWEN = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// burst, round-robin, error and asynchronous-reset sequences.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam word_t IA0 = 32'h0000_0040;
  localparam word_t IA1 = 32'h0000_0400;
  localparam word_t DA0 = 32'h0000_0100;
  localparam word_t DA1 = 32'h0000_0300;
  localparam word_t DS0 = 32'hA0A0_A0A0;
  localparam word_t DS1 = 32'hB1B1_B1B1;
  localparam word_t LD1 = 32'hDEAD_BEEF;
  localparam word_t LD2 = 32'h1234_5678;
  localparam word_t LD3 = 32'hCAFE_F00D;
  localparam int    NV  = 14;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  iREN, dREN, dWEN;
  logic [63:0] iaddr, daddr, dstore;
  logic [1:0]  iwait, dwait;
  logic [63:0] iload, dload;
  logic        ramREN, ramWEN;
  word_t       ramaddr, ramstore, ramload;
  ramstate_t   ramstate;
  logic        arb_err;
  arbstate_t   arb_state;
  logic [1:0]  arb_owner;

  int total_cnt = 0;
  int bad_cnt   = 0;

  typedef struct {
    logic [1:0]  iren;
    logic [1:0]  dren;
    logic [1:0]  dwen;
    ramstate_t   rs;
    word_t       load;
    logic        ren;
    logic        wen;
    word_t       addr;
    logic [1:0]  iw;
    logic [1:0]  dw;
    arbstate_t   st;
    logic [63:0] il;
    logic [63:0] dl;
  } vec_t;

  vec_t vecs [NV];

  mem_arbiter #(.CPUS(2), .MAX_BURST(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dwait     (dwait),
    .dload     (dload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramstate  (ramstate),
    .arb_err   (arb_err),
    .arb_state (arb_state),
    .arb_owner (arb_owner)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    iREN     = '0;
    dREN     = '0;
    dWEN     = '0;
    ramload  = '0;
    ramstate = FREE;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_inputs();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  function automatic vec_t mk(input logic [1:0] iren, input logic [1:0] dren,
                              input logic [1:0] dwen, input ramstate_t rs, input word_t load,
                              input logic ren, input logic wen, input word_t addr,
                              input logic [1:0] iw, input logic [1:0] dw, input arbstate_t st,
                              input logic [63:0] il, input logic [63:0] dl);
    vec_t v;
    v.iren = iren; v.dren = dren; v.dwen = dwen; v.rs = rs; v.load = load;
    v.ren = ren; v.wen = wen; v.addr = addr; v.iw = iw; v.dw = dw; v.st = st;
    v.il = il; v.dl = dl;
    return v;
  endfunction

  task automatic load_vectors();
    // single icache read: two BUSY then ACCESS
    vecs[0]  = mk(2'b01, 2'b00, 2'b00, FREE,   '0,  0, 0, '0,  2'b11, 2'b11, ARB_IDLE,  '0, '0);
    vecs[1]  = mk(2'b01, 2'b00, 2'b00, BUSY,   LD1, 1, 0, IA0, 2'b11, 2'b11, ARB_GRANT, {32'h0, LD1}, '0);
    vecs[2]  = mk(2'b01, 2'b00, 2'b00, BUSY,   LD1, 1, 0, IA0, 2'b11, 2'b11, ARB_GRANT, {32'h0, LD1}, '0);
    vecs[3]  = mk(2'b01, 2'b00, 2'b00, ACCESS, LD1, 1, 0, IA0, 2'b10, 2'b11, ARB_GRANT, {32'h0, LD1}, '0);
    vecs[4]  = mk(2'b00, 2'b00, 2'b00, FREE,   LD1, 0, 0, '0,  2'b11, 2'b11, ARB_IDLE,  '0, '0);
    // dcache0 writes 2 words then reads 2 words atomically; icache1 waits
    vecs[5]  = mk(2'b00, 2'b00, 2'b01, FREE,   '0,  0, 0, '0,  2'b11, 2'b11, ARB_IDLE,  '0, '0);
    vecs[6]  = mk(2'b10, 2'b00, 2'b01, ACCESS, LD2, 0, 1, DA0, 2'b11, 2'b10, ARB_GRANT, '0, {32'h0, LD2});
    vecs[7]  = mk(2'b10, 2'b00, 2'b01, ACCESS, LD2, 0, 1, DA0, 2'b11, 2'b10, ARB_GRANT, '0, {32'h0, LD2});
    vecs[8]  = mk(2'b10, 2'b01, 2'b00, BUSY,   LD2, 1, 0, DA0, 2'b11, 2'b11, ARB_GRANT, '0, {32'h0, LD2});
    vecs[9]  = mk(2'b10, 2'b01, 2'b00, ACCESS, LD2, 1, 0, DA0, 2'b11, 2'b10, ARB_GRANT, '0, {32'h0, LD2});
    vecs[10] = mk(2'b10, 2'b01, 2'b00, ACCESS, LD2, 1, 0, DA0, 2'b11, 2'b10, ARB_GRANT, '0, {32'h0, LD2});
    vecs[11] = mk(2'b10, 2'b00, 2'b00, FREE,   LD2, 0, 0, '0,  2'b11, 2'b11, ARB_IDLE,  '0, '0);
    vecs[12] = mk(2'b10, 2'b00, 2'b00, ACCESS, LD3, 1, 0, IA1, 2'b01, 2'b11, ARB_GRANT, {LD3, 32'h0}, '0);
    vecs[13] = mk(2'b00, 2'b00, 2'b00, FREE,   '0,  0, 0, '0,  2'b11, 2'b11, ARB_IDLE,  '0, '0);
  endtask

  // dcache0 wants 6 reads against a cap of 4 while icache1 waits
  task automatic seq_burst();
    int         dcnt     = 0;
    bit         i1_done  = 0;
    bit         in_grant = 0;
    bit         fin      = 0;
    logic [1:0] got_q[$];
    int         acc_q[$];
    logic [1:0] exp_q[$];
    int         exp_acc[$];
`ifdef MEM_ARB_DPRIO_EN
    exp_q   = '{2'd0, 2'd0, 2'd3};
    exp_acc = '{4, 2, 1};
`else
    exp_q   = '{2'd0, 2'd3, 2'd0};
    exp_acc = '{4, 1, 2};
`endif
    for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
      @(negedge CLK);
      dREN     = {1'b0, (dcnt < 6)};
      iREN     = {~i1_done, 1'b0};
      ramstate = ((dcnt < 6) || !i1_done) ? ACCESS : FREE;
      #1;
      if (arb_state == ARB_GRANT && !in_grant) begin
        got_q.push_back(arb_owner);
        acc_q.push_back(0);
      end
      in_grant = (arb_state == ARB_GRANT);
      if (ramREN && !dwait[0] && acc_q.size() > 0) begin
        dcnt++;
        acc_q[acc_q.size()-1]++;
      end
      if (ramREN && !iwait[1] && acc_q.size() > 0) begin
        i1_done = 1;
        acc_q[acc_q.size()-1]++;
      end
      if (dcnt >= 6 && i1_done && arb_state == ARB_IDLE) fin = 1;
    end
    chk("burst_finished", 64'(fin), 64'd1);
    chk("burst_ngrants", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("burst_owner%0d", i), 64'(got_q[i]), 64'(exp_q[i]));
      chk($sformatf("burst_acc%0d", i), 64'(acc_q[i]), 64'(exp_acc[i]));
    end
    clear_inputs();
  endtask

  // all four requesters held with the RAM always ready
  task automatic seq_rr();
    bit         in_grant = 0;
    logic [1:0] got_q[$];
    logic [1:0] exp_q[$];
    logic [1:0] got;
`ifdef MEM_ARB_DPRIO_EN
    exp_q = '{2'd0, 2'd2, 2'd0, 2'd2, 2'd0};
`else
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
    do_reset();
    iREN     = 2'b11;
    dREN     = 2'b11;
    ramstate = ACCESS;
    for (int cyc = 0; cyc < 80 && got_q.size() < 5; cyc++) begin
      @(negedge CLK);
      #1;
      if (arb_state == ARB_GRANT && !in_grant) got_q.push_back(arb_owner);
      in_grant = (arb_state == ARB_GRANT);
    end
    chk("rr_ngrants", 64'(got_q.size()), 64'd5);
    for (int i = 0; i < 5 && got_q.size() > 0; i++) begin
      got = got_q.pop_front();
      chk($sformatf("rr_owner%0d", i), 64'(got), 64'(exp_q.pop_front()));
    end
    @(negedge CLK);
    clear_inputs();
    repeat (2) @(negedge CLK);
  endtask

  // ERROR during a dcache1 write: sticky flag, enables dropped, same owner retried
  task automatic seq_error();
    @(negedge CLK);
    dWEN = 2'b10; ramstate = FREE;
    #1;
    chk("err_pre_state", arb_state, ARB_IDLE);
    chk("err_pre_flag", arb_err, 1'b0);
    @(negedge CLK);
    ramstate = BUSY;
    #1;
    chk("err_g_state", arb_state, ARB_GRANT);
    chk("err_g_owner", arb_owner, 2'd2);
    chk("err_g_wen", ramWEN, 1'b1);
    chk("err_g_ren", ramREN, 1'b0);
    chk("err_g_addr", ramaddr, DA1);
    chk("err_g_store", ramstore, DS1);
    chk("err_g_dwait", dwait, 2'b11);
    @(negedge CLK);
    ramstate = ERROR;
    #1;
    chk("err_e_wen", ramWEN, 1'b0);
    chk("err_e_dwait", dwait, 2'b11);
    @(negedge CLK);
    ramstate = FREE;
    #1;
    chk("err_i_state", arb_state, ARB_IDLE);
    chk("err_i_flag", arb_err, 1'b1);
    chk("err_i_dwait", dwait, 2'b11);
    @(negedge CLK);
    ramstate = BUSY;
    #1;
    chk("err_r_state", arb_state, ARB_GRANT);
    chk("err_r_owner", arb_owner, 2'd2);
    chk("err_r_wen", ramWEN, 1'b1);
    chk("err_r_dwait", dwait, 2'b11);
    @(negedge CLK);
    ramstate = ACCESS;
    #1;
    chk("err_a_dwait", dwait, 2'b01);
    chk("err_a_flag", arb_err, 1'b1);
    @(negedge CLK);
    dWEN = 2'b00; ramstate = FREE;
    #1;
    chk("err_d_wen", ramWEN, 1'b0);
  endtask

  // RST raised between clock edges while ramWEN is high
  task automatic seq_reset();
    @(negedge CLK);
    dWEN = 2'b01; ramstate = BUSY;
    #1;
    chk("ar_pre_state", arb_state, ARB_IDLE);
    @(negedge CLK);
    #1;
    chk("ar_g_wen", ramWEN, 1'b1);
    chk("ar_g_flag", arb_err, 1'b1);
    #1;
    RST = 1'b1;
    #1;
    chk("ar_wen", ramWEN, 1'b0);
    chk("ar_ren", ramREN, 1'b0);
    chk("ar_iwait", iwait, 2'b11);
    chk("ar_dwait", dwait, 2'b11);
    chk("ar_flag", arb_err, 1'b0);
    chk("ar_state", arb_state, ARB_IDLE);
    chk("ar_owner", arb_owner, 2'd0);
    @(negedge CLK);
    clear_inputs();
    RST = 1'b0;
  endtask

  initial begin
    iaddr  = {IA1, IA0};
    daddr  = {DA1, DA0};
    dstore = {DS1, DS0};
    do_reset();
    #1;
    chk("rst_state", arb_state, ARB_IDLE);
    chk("rst_owner", arb_owner, 2'd0);
    chk("rst_ren", ramREN, 1'b0);
    chk("rst_wen", ramWEN, 1'b0);
    chk("rst_addr", ramaddr, 32'h0);
    chk("rst_store", ramstore, 32'h0);
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_flag", arb_err, 1'b0);

    load_vectors();
    for (int i = 0; i < NV; i++) begin
      @(negedge CLK);
      iREN     = vecs[i].iren;
      dREN     = vecs[i].dren;
      dWEN     = vecs[i].dwen;
      ramstate = vecs[i].rs;
      ramload  = vecs[i].load;
      #1;
      chk($sformatf("v%0d_state", i), arb_state, vecs[i].st);
      chk($sformatf("v%0d_ren", i), ramREN, vecs[i].ren);
      chk($sformatf("v%0d_wen", i), ramWEN, vecs[i].wen);
      chk($sformatf("v%0d_addr", i), ramaddr, vecs[i].addr);
      chk($sformatf("v%0d_iwait", i), iwait, vecs[i].iw);
      chk($sformatf("v%0d_dwait", i), dwait, vecs[i].dw);
      chk($sformatf("v%0d_iload", i), iload, vecs[i].il);
      chk($sformatf("v%0d_dload", i), dload, vecs[i].dl);
    end

    seq_burst();
    seq_rr();
    seq_error();
    seq_reset();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port among the instruction and data caches of CPUS cores. Sits between the per-core icache/dcache and the RAM model.
- Grants one requester at a time and routes that requester's address, data and enables to RAM; returns a wait/load pair to each requester.
- Keeps a multi-word dcache transaction atomic (writeback plus two-word fill) up to a burst cap. Then re-arbitrates round-robin.

Parameters:
- CPUS, 2, number of cores; requesters = 2*CPUS.
- MAX_BURST, 4, maximum completed RAM accesses per grant before forced release.

Ports:
- CLK in 1: clock.
- RST in 1: asynchronous, active-high reset.
- iREN in CPUS: icache read request, per core.
- iaddr in 32*CPUS: icache word address, core c at [32c+31:32c].
- iwait out CPUS: icache stall, per core.
- iload out 32*CPUS: icache read data, per core.
- dREN in CPUS: dcache read request, per core.
- dWEN in CPUS: dcache write request, per core.
- daddr in 32*CPUS: dcache word address, per core.
- dstore in 32*CPUS: dcache write data, per core.
- dwait out CPUS: dcache stall, per core.
- dload out 32*CPUS: dcache read data, per core.
- ramREN out 1: RAM read enable.
- ramWEN out 1: RAM write enable.
- ramaddr out 32: RAM address.
- ramstore out 32: RAM write data.
- ramload in 32: RAM read data.
- ramstate in 2: RAM status, one of FREE, BUSY, ACCESS, ERROR.
- arb_err out 1: sticky flag, set when RAM reports ERROR.

Behaviour:
- Reset values: state=ARB_IDLE, owner=0, burst count=0, rr pointer=0, ramREN=ramWEN=0, ramaddr=ramstore=0, all iwait/dwait=1, arb_err=0. Reset asserted mid-transfer aborts it immediately; no partial RAM enable survives the asynchronous edge.
- Requester index: dcache of core c = 2c, icache of core c = 2c+1.
- ARB_IDLE:
  - If any request is present, register the winner as owner, clear burst count, go to ARB_GRANT. RAM enables stay low this cycle.
  - A request takes at least 1 cycle before it reaches the RAM.
- Winner selection: round-robin across the 2*CPUS requesters, starting at rr pointer. On release, rr pointer = owner+1, modulo 2*CPUS.
- ARB_GRANT:
  - Owner's address, store data and enables drive RAM combinationally. If dcache dWEN and dREN are both high, the write wins.
  - Owner's wait = (ramstate != ACCESS). Owner's load = ramload. Every non-owner's wait = 1 and load = 0.
  - On each cycle with ramstate==ACCESS, burst count increments, saturating at MAX_BURST.
- Release: go to ARB_IDLE on whichever comes first:
  - the owner drops all of its request lines;
  - ramstate==ACCESS with the owner being an icache (single word);
  - burst count reaches MAX_BURST on an ACCESS cycle.
- ERROR: ramstate==ERROR in ARB_GRANT sets arb_err, keeps owner wait=1, drops RAM enables, and goes to ARB_IDLE without advancing the rr pointer so the same owner retries. arb_err clears only on RST.
- An owner changing its address mid-grant gets no special handling. It is routed as-is; the RAM is responsible for restarting the access.
- Release and a new request in the same cycle: the new request is arbitrated in the following ARB_IDLE cycle, giving one dead cycle between grants.

Optional Feature:
- MEM_ARB_DPRIO_EN defined: any pending dcache request beats any pending icache request. Round-robin applies within each class, using separate dcache and icache pointers.
- MEM_ARB_DPRIO_EN undefined: flat round-robin over all 2*CPUS requesters, as described above.

Decomposition:
- Shared package cpu_types_pkg, which already carries word_t:
  - ramstate_t enum: FREE=2'b00, BUSY=2'b01, ACCESS=2'b10, ERROR=2'b11.
  - arbstate_t enum: ARB_IDLE, ARB_GRANT.
- One sub-module rr_picker: request vector, pointer in → one-hot grant plus index out; parameterised width. Instantiated once, or twice when MEM_ARB_DPRIO_EN is defined.

Test Plan:
- Reset, then core0 iREN with iaddr=0x40; RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF. Required: ramREN high from cycle 2, iwait[0] low only on the ACCESS cycle with iload=0xDEADBEEF, arbiter back in IDLE the next cycle.
- core0 dcache asserts dWEN for 2 words then dREN for 2 words while core1 iREN is held high. Required: all 4 accesses complete consecutively for core0 with iwait[1]=1 throughout; core1 is granted after release.
- dcache holds dREN for 6 accesses with MAX_BURST=4. Required: forced release after the 4th ACCESS; another pending requester is granted; the dcache resumes later.
- All four requesters asserted continuously, flat mode. Required: grant order 0,1,2,3,0; with MEM_ARB_DPRIO_EN defined, order 0,2,0,2 until the dcaches drop.
- ramstate=ERROR during a core1 dcache write. Required: arb_err=1, ramWEN drops, core1 is regranted next, dwait[1] stays 1 until a later ACCESS.
- RST pulsed while ramWEN=1. Required: ramWEN=0 asynchronously, all waits=1, arb_err=0, state ARB_IDLE.
